// File: rtl/vec_load_unit_pkg.sv
// Shared constants, state type and lane helpers for the vector load unit.
package vlu_pkg;

    localparam int VLU_LANES = 4;
    localparam int REG_AW    = 6;
    localparam int XLEN      = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        WB
    } vlu_state_t;

    // Lowest lane index >= from that is marked for fetch; VLU_LANES means none left.
    function automatic logic [2:0] next_lane(input logic [VLU_LANES-1:0] fetch,
                                             input logic [2:0]           from);
        logic [2:0] found;
        found = 3'(VLU_LANES);
        for (int i = VLU_LANES - 1; i >= 0; i--) begin
            if (fetch[i] && (3'(i) >= from)) begin
                found = 3'(i);
            end
        end
        return found;
    endfunction

    function automatic logic [XLEN-1:0] lane_addr(input logic [XLEN-1:0] base,
                                                   input logic [1:0]      lane);
        return base + {{(XLEN-4){1'b0}}, lane, 2'b00};
    endfunction

endpackage

// File: rtl/vec_load_unit_if.sv
// Request, memory and register-file write signals of the vector load unit.
interface vec_load_unit_if;
    import vlu_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [XLEN-1:0]      req_base;
    logic [REG_AW-1:0]    req_rd0;
    logic [REG_AW-1:0]    req_rd1;
    logic [REG_AW-1:0]    req_rd2;
    logic [REG_AW-1:0]    req_rd3;
    logic [VLU_LANES-1:0] req_mask;

    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [XLEN-1:0]      mem_req_addr;
    logic                 mem_resp_valid;
    logic [XLEN-1:0]      mem_resp_data;

    logic                 vecwe;
    logic [REG_AW-1:0]    waddr2;
    logic [REG_AW-1:0]    waddr3;
    logic [REG_AW-1:0]    waddr4;
    logic [REG_AW-1:0]    waddr5;
    logic [XLEN-1:0]      wdata2;
    logic [XLEN-1:0]      wdata3;
    logic [XLEN-1:0]      wdata4;
    logic [XLEN-1:0]      wdata5;
    logic                 busy;

    // The load unit itself is the master side.
    modport master (
        input  req_valid, req_base, req_rd0, req_rd1, req_rd2, req_rd3, req_mask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_ready, mem_req_valid, mem_req_addr,
        output vecwe, waddr2, waddr3, waddr4, waddr5,
        output wdata2, wdata3, wdata4, wdata5, busy
    );

    modport slave (
        output req_valid, req_base, req_rd0, req_rd1, req_rd2, req_rd3, req_mask,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  req_ready, mem_req_valid, mem_req_addr,
        input  vecwe, waddr2, waddr3, waddr4, waddr5,
        input  wdata2, wdata3, wdata4, wdata5, busy
    );

endinterface

// File: rtl/vec_load_unit.sv
// Vector load unit: fetches up to four words, one request at a time, then writes them as one vector.
// Build option VLU_SKIP_MASKED_EN: lanes with a clear mask bit are not fetched at all.
module vec_load_unit
    import vlu_pkg::*;
(
    input logic             clk,
    input logic             rstn,
    vec_load_unit_if.master bus
);

    vlu_state_t           state;
    logic [1:0]           lane;
    logic [XLEN-1:0]      base;
    logic [REG_AW-1:0]    rd     [VLU_LANES];
    logic [VLU_LANES-1:0] mask;
    logic [XLEN-1:0]      buffer [VLU_LANES];

    logic                 req_ready;
    logic                 busy;
    logic                 mem_req_valid;
    logic [XLEN-1:0]      mem_req_addr;
    logic                 vecwe;
    logic [REG_AW-1:0]    waddr  [VLU_LANES];
    logic [XLEN-1:0]      wdata  [VLU_LANES];

    logic [VLU_LANES-1:0] req_fetch;
    logic [VLU_LANES-1:0] held_fetch;
    logic                 resp_take;
    logic [2:0]           first_lane;
    logic [2:0]           following_lane;
    logic [XLEN-1:0]      landed [VLU_LANES];

`ifdef VLU_SKIP_MASKED_EN
    assign req_fetch  = bus.req_mask;
    assign held_fetch = mask;
`else
    assign req_fetch  = '1;
    assign held_fetch = '1;
`endif

    // landed is the buffer as it will look once the response arriving this cycle is stored,
    // so the write-back outputs can be registered on the same edge.
    always_comb begin
        resp_take = (state == WAIT) && bus.mem_resp_valid;
        for (int i = 0; i < VLU_LANES; i++) begin
            landed[i] = buffer[i];
        end
        if (resp_take) begin
            landed[lane] = bus.mem_resp_data;
        end
        first_lane     = next_lane(req_fetch, 3'd0);
        following_lane = next_lane(held_fetch, {1'b0, lane} + 3'd1);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            lane          <= '0;
            base          <= '0;
            mask          <= '0;
            req_ready     <= 1'b1;
            busy          <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            vecwe         <= 1'b0;
            for (int i = 0; i < VLU_LANES; i++) begin
                rd[i]     <= '0;
                buffer[i] <= '0;
                waddr[i]  <= '0;
                wdata[i]  <= '0;
            end
        end else begin
            vecwe <= 1'b0;
            for (int i = 0; i < VLU_LANES; i++) begin
                waddr[i] <= '0;
                wdata[i] <= '0;
            end
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        base      <= bus.req_base;
                        rd[0]     <= bus.req_rd0;
                        rd[1]     <= bus.req_rd1;
                        rd[2]     <= bus.req_rd2;
                        rd[3]     <= bus.req_rd3;
                        mask      <= bus.req_mask;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        // Nothing to fetch only happens for an all-clear mask, so the write is all zeros.
                        if (first_lane == 3'(VLU_LANES)) begin
                            state <= WB;
                            lane  <= '0;
                            vecwe <= 1'b1;
                        end else begin
                            state         <= ISSUE;
                            lane          <= first_lane[1:0];
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= lane_addr(bus.req_base, first_lane[1:0]);
                        end
                    end
                end
                ISSUE: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (resp_take) begin
                        buffer[lane] <= bus.mem_resp_data;
                        if (following_lane == 3'(VLU_LANES)) begin
                            state <= WB;
                            vecwe <= 1'b1;
                            for (int i = 0; i < VLU_LANES; i++) begin
                                if (mask[i]) begin
                                    waddr[i] <= rd[i];
                                    wdata[i] <= landed[i];
                                end
                            end
                        end else begin
                            state         <= ISSUE;
                            lane          <= following_lane[1:0];
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= lane_addr(base, following_lane[1:0]);
                        end
                    end
                end
                WB: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready     = req_ready;
    assign bus.busy          = busy;
    assign bus.mem_req_valid = mem_req_valid;
    assign bus.mem_req_addr  = mem_req_addr;
    assign bus.vecwe         = vecwe;
    assign bus.waddr2        = waddr[0];
    assign bus.waddr3        = waddr[1];
    assign bus.waddr4        = waddr[2];
    assign bus.waddr5        = waddr[3];
    assign bus.wdata2        = wdata[0];
    assign bus.wdata3        = wdata[1];
    assign bus.wdata4        = wdata[2];
    assign bus.wdata5        = wdata[3];

endmodule

// File: tb/tb_vec_load_unit.sv
// Bench for vec_load_unit: directed loads, a behavioural memory and a per-cycle reference model.
// Follows VLU_SKIP_MASKED_EN the same way the design does.
module tb_vec_load_unit;
    import vlu_pkg::*;

`ifdef VLU_SKIP_MASKED_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    vec_load_unit_if bus();

    vec_load_unit dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Memory: accepts when valid&ready, answers resp_delay cycles later with addr^0xA5.
    int          resp_delay = 1;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    int          stall_left = 0;
    bit          spurious   = 1'b0;
    int          pend_cnt   = 0;
    logic [31:0] pend_addr  = '0;
    logic [31:0] acc_log[$];

    initial begin
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = '0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_data  = pend_addr ^ 32'hA5;
                end
            end
            if (spurious) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = 32'hDEAD_BEEF;
                spurious = 1'b0;
            end
            if (bus.mem_req_valid === 1'b1 && bus.mem_req_addr == stall_addr && stall_left > 0) begin
                bus.mem_req_ready = 1'b0;
                stall_left--;
            end else begin
                bus.mem_req_ready = 1'b1;
            end
            if (bus.mem_req_valid === 1'b1 && bus.mem_req_ready && rstn) begin
                pend_cnt  = resp_delay;
                pend_addr = bus.mem_req_addr;
                acc_log.push_back(bus.mem_req_addr);
            end
        end
    end

    // Reference model: a load occupies the cycles after its handshake up to its write-back cycle.
    bit               m_active = 1'b0;
    int               m_hs     = 0;
    int               m_wb     = 0;
    logic [31:0]      m_addr_q[$];
    logic [3:0][5:0]  m_waddr  = '0;
    logic [3:0][31:0] m_wdata  = '0;
    bit               prev_stall = 1'b0;
    logic [31:0]      prev_addr  = '0;

    initial begin
        bit          exp_busy;
        bit          exp_we;
        int          t;
        logic [31:0] a;
        logic [5:0]  rds[4];
        forever begin
            @(negedge clk);
            #3;
            if (!rstn) begin
                m_active   = 1'b0;
                m_addr_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (m_active && cyc > m_wb) m_active = 1'b0;
                exp_busy = m_active && (cyc > m_hs);
                exp_we   = m_active && (cyc == m_wb);
                checkOutput("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
                checkOutput("req_ready", {31'd0, bus.req_ready}, {31'd0, !exp_busy});
                checkOutput("vecwe", {31'd0, bus.vecwe}, {31'd0, exp_we});
                checkOutput("waddr", {8'd0, bus.waddr5, bus.waddr4, bus.waddr3, bus.waddr2},
                            exp_we ? {8'd0, m_waddr} : 32'd0);
                checkOutput("wdata2", bus.wdata2, exp_we ? m_wdata[0] : 32'd0);
                checkOutput("wdata3", bus.wdata3, exp_we ? m_wdata[1] : 32'd0);
                checkOutput("wdata4", bus.wdata4, exp_we ? m_wdata[2] : 32'd0);
                checkOutput("wdata5", bus.wdata5, exp_we ? m_wdata[3] : 32'd0);
                if (!exp_busy) checkOutput("mem_req_valid_idle", {31'd0, bus.mem_req_valid}, 32'd0);
                if (prev_stall) begin
                    checkOutput("mem_req_valid_held", {31'd0, bus.mem_req_valid}, 32'd1);
                    checkOutput("mem_req_addr_held", bus.mem_req_addr, prev_addr);
                end
                if (bus.mem_req_valid && bus.mem_req_ready) begin
                    if (m_addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL mem_req_unexpected: got addr 0x%0h, expected no request", bus.mem_req_addr);
                    end else begin
                        checkOutput("mem_req_addr", bus.mem_req_addr, m_addr_q.pop_front());
                    end
                end
                prev_stall = bus.mem_req_valid && !bus.mem_req_ready;
                prev_addr  = bus.mem_req_addr;
                if (!m_active && bus.req_valid) begin
                    m_active = 1'b1;
                    m_hs     = cyc;
                    rds      = '{bus.req_rd0, bus.req_rd1, bus.req_rd2, bus.req_rd3};
                    t        = cyc + 1;
                    for (int i = 0; i < 4; i++) begin
                        a = bus.req_base + 32'(4 * i);
                        m_waddr[i] = bus.req_mask[i] ? rds[i] : 6'd0;
                        m_wdata[i] = bus.req_mask[i] ? (a ^ 32'hA5) : 32'd0;
                        if (bus.req_mask[i] || !SKIP) begin
                            m_addr_q.push_back(a);
                            t += 1 + resp_delay + ((a == stall_addr) ? stall_left : 0);
                        end
                    end
                    m_wb = t;
                end
            end
        end
    end

    bit hold_valid = 1'b0;

    task automatic applyStimulus(input logic [31:0] base, input logic [5:0] r0, input logic [5:0] r1,
                                 input logic [5:0] r2, input logic [5:0] r3, input logic [3:0] m);
        @(negedge clk);
        acc_log.delete();
        bus.req_valid = 1'b1;
        bus.req_base  = base;
        bus.req_rd0   = r0;
        bus.req_rd1   = r1;
        bus.req_rd2   = r2;
        bus.req_rd3   = r3;
        bus.req_mask  = m;
    endtask

    task automatic waitVecwe(input int lat0, output int lat, output logic [3:0][5:0] wa,
                             output logic [3:0][31:0] wd);
        bit seen;
        seen = 1'b0;
        lat  = lat0;
        wa   = '0;
        wd   = '0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (!hold_valid) bus.req_valid = 1'b0;
            #3;
            lat++;
            if (bus.vecwe) begin
                seen = 1'b1;
                wa   = {bus.waddr5, bus.waddr4, bus.waddr3, bus.waddr2};
                wd   = {bus.wdata5, bus.wdata4, bus.wdata3, bus.wdata2};
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL vecwe_timeout: got no vecwe, expected one within 60 cycles");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int               lat;
        int               n_we;
        int               n_mreq;
        logic [3:0][5:0]  wa;
        logic [3:0][31:0] wd;

        bus.req_valid = 1'b0;
        bus.req_base  = '0;
        bus.req_rd0   = '0;
        bus.req_rd1   = '0;
        bus.req_rd2   = '0;
        bus.req_rd3   = '0;
        bus.req_mask  = '0;

        repeat (3) @(negedge clk);
        #3;
        checkOutput("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
        checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset_vecwe", {31'd0, bus.vecwe}, 32'd0);
        checkOutput("reset_mem_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        idle(2);

        $display("[TB] full-mask load at 0x100");
        applyStimulus(32'h100, 6'd1, 6'd2, 6'd33, 6'd34, 4'hF);
        waitVecwe(0, lat, wa, wd);
        checkOutput("full_latency", lat, 9);
        checkOutput("full_waddr", {8'd0, wa}, {8'd0, 6'd34, 6'd33, 6'd2, 6'd1});
        checkOutput("full_wdata2", wd[0], 32'h1A5);
        checkOutput("full_wdata3", wd[1], 32'h1A1);
        checkOutput("full_wdata4", wd[2], 32'h1AD);
        checkOutput("full_wdata5", wd[3], 32'h1A9);
        checkOutput("full_req_count", acc_log.size(), 4);
        checkOutput("full_addr3", acc_log[3], 32'h10C);
        idle(2);

        $display("[TB] mask 0x5 load");
        applyStimulus(32'h100, 6'd1, 6'd2, 6'd33, 6'd34, 4'h5);
        waitVecwe(0, lat, wa, wd);
        checkOutput("mask5_latency", lat, SKIP ? 5 : 9);
        checkOutput("mask5_waddr", {8'd0, wa}, {8'd0, 6'd0, 6'd33, 6'd0, 6'd1});
        checkOutput("mask5_wdata3", wd[1], 32'h0);
        checkOutput("mask5_wdata4", wd[2], 32'h1AD);
        checkOutput("mask5_wdata5", wd[3], 32'h0);
        checkOutput("mask5_req_count", acc_log.size(), SKIP ? 2 : 4);
        checkOutput("mask5_addr1", acc_log[1], SKIP ? 32'h108 : 32'h104);
        idle(2);

        $display("[TB] lane 2 stalled three cycles");
        stall_addr = 32'h108;
        stall_left = 3;
        applyStimulus(32'h100, 6'd1, 6'd2, 6'd33, 6'd34, 4'hF);
        waitVecwe(0, lat, wa, wd);
        checkOutput("stall_latency", lat, 12);
        checkOutput("stall_wdata4", wd[2], 32'h1AD);
        stall_addr = 32'hFFFF_FFFF;
        idle(2);

        $display("[TB] wrapping addresses");
        applyStimulus(32'hFFFF_FFF8, 6'd40, 6'd41, 6'd42, 6'd43, 4'hF);
        waitVecwe(0, lat, wa, wd);
        checkOutput("wrap_addr0", acc_log[0], 32'hFFFF_FFF8);
        checkOutput("wrap_addr1", acc_log[1], 32'hFFFF_FFFC);
        checkOutput("wrap_addr2", acc_log[2], 32'h0000_0000);
        checkOutput("wrap_addr3", acc_log[3], 32'h0000_0004);
        checkOutput("wrap_wdata3", wd[1], 32'hFFFF_FF59);
        checkOutput("wrap_wdata4", wd[2], 32'h0000_00A5);
        idle(2);

        $display("[TB] empty mask");
        applyStimulus(32'h700, 6'd9, 6'd9, 6'd9, 6'd9, 4'h0);
        waitVecwe(0, lat, wa, wd);
        checkOutput("mask0_latency", lat, SKIP ? 1 : 9);
        checkOutput("mask0_waddr", {8'd0, wa}, 32'd0);
        idle(2);

        $display("[TB] reset while waiting on lane 1");
        resp_delay = 3;
        applyStimulus(32'h200, 6'd3, 6'd4, 6'd5, 6'd6, 4'hF);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        n_we   = 0;
        n_mreq = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            #3;
            if (bus.vecwe) n_we++;
            if (bus.mem_req_valid) n_mreq++;
        end
        checkOutput("abort_vecwe_count", n_we, 0);
        checkOutput("abort_mem_req_count", n_mreq, 0);
        checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
        resp_delay = 1;
        applyStimulus(32'h300, 6'd5, 6'd6, 6'd7, 6'd8, 4'hF);
        waitVecwe(0, lat, wa, wd);
        checkOutput("after_abort_latency", lat, 9);
        checkOutput("after_abort_wdata2", wd[0], 32'h3A5);
        checkOutput("after_abort_waddr", {8'd0, wa}, {8'd0, 6'd8, 6'd7, 6'd6, 6'd5});
        idle(2);

        $display("[TB] spurious response and held request");
        @(negedge clk);
        spurious = 1'b1;
        applyStimulus(32'h400, 6'd10, 6'd11, 6'd12, 6'd13, 4'hF);
        hold_valid = 1'b1;
        @(negedge clk);
        bus.req_base = 32'h500;
        bus.req_rd0  = 6'd20;
        bus.req_rd1  = 6'd21;
        bus.req_rd2  = 6'd22;
        bus.req_rd3  = 6'd23;
        bus.req_mask = 4'h3;
        waitVecwe(1, lat, wa, wd);
        checkOutput("held_latency", lat, 9);
        checkOutput("held_waddr", {8'd0, wa}, {8'd0, 6'd13, 6'd12, 6'd11, 6'd10});
        checkOutput("held_wdata2", wd[0], 32'h4A5);
        checkOutput("held_wdata5", wd[3], 32'h4A9);
        @(negedge clk);
        #3;
        checkOutput("held_ready_after_wb", {31'd0, bus.req_ready}, 32'd1);
        hold_valid = 1'b0;
        waitVecwe(1, lat, wa, wd);
        checkOutput("second_gap", lat, SKIP ? 6 : 10);
        checkOutput("second_waddr", {8'd0, wa}, {8'd0, 6'd0, 6'd0, 6'd21, 6'd20});
        checkOutput("second_wdata2", wd[0], 32'h5A5);
        checkOutput("second_wdata4", wd[2], 32'h0);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vec_load_unit.md
VEC_LOAD_UNIT -- requirements
Module: vec_load_unit

Interface
REQ-001 The block SHALL expose these ports: clk  in  1  sole clock, rising edge.
REQ-002 The block SHALL expose rstn  in  1  reset, synchronous, active-low.
REQ-003 The block SHALL expose req_valid in 1 / req_ready out 1  vector-load request handshake.
REQ-004 The block SHALL expose req_base  in  32  byte address of lane 0; lane i address = req_base + 4*i, modulo 2^32.
REQ-005 The block SHALL expose req_rd0..req_rd3  in  6 each  destination register per lane (0-31 int, 32-63 fp).
REQ-006 The block SHALL expose req_mask  in  4  lane enable, bit i = lane i.
REQ-007 The block SHALL expose mem_req_valid out 1 / mem_req_ready in 1 / mem_req_addr out 32  word read request.
REQ-008 The block SHALL expose mem_resp_valid in 1 / mem_resp_data in 32  read response, in order.
REQ-009 The block SHALL expose vecwe  out 1  one-cycle register-file vector write strobe.
REQ-010 The block SHALL expose waddr2..waddr5  out 6 each and wdata2..wdata5  out 32 each, lanes 0..3.
REQ-011 The block SHALL expose busy  out 1  high whenever state != IDLE.

Function
REQ-012 FSM states SHALL be IDLE, ISSUE, WAIT, WB.
REQ-013 req_ready SHALL equal (state == IDLE); handshake on req_valid & req_ready latches base, rd0..3, mask; lane counter := first lane to fetch.
REQ-014 IDLE->ISSUE on handshake; ISSUE asserts mem_req_valid with current lane address, holds it stable until mem_req_ready, then ->WAIT.
REQ-015 WAIT: on mem_resp_valid, store mem_resp_data in current lane buffer; ->ISSUE for next lane, or ->WB after last lane.
REQ-016 At most one memory request SHALL be outstanding; mem_resp_valid outside WAIT SHALL be ignored.
REQ-017 WB: vecwe=1 for exactly one cycle, then ->IDLE; req_ready rises the following cycle.
REQ-018 In WB, waddr(2+i) SHALL be rd_i if mask[i], else 0; wdata(2+i) SHALL be buffer_i if mask[i], else 0.
REQ-019 Outside WB, vecwe SHALL be 0 and waddr/wdata outputs SHALL be 0.
REQ-020 Minimum latency with mem_req_ready=1 and 1-cycle response: handshake at cycle 0, 4 lanes x 2 cycles, vecwe at cycle 9.
REQ-021 Address arithmetic SHALL wrap: base 0xFFFF_FFFC gives lane 1 address 0x0000_0000.
REQ-022 Request fields SHALL NOT be re-sampled after handshake; input changes while busy have no effect.

Reset
REQ-023 While rstn=0 at a clock edge: state:=IDLE, lane counter and buffers :=0, all outputs 0 except req_ready=1 after the edge.
REQ-024 Reset mid-operation SHALL abort the load, with no vecwe and no further mem_req_valid; a late response is ignored per REQ-016.

Configuration
REQ-025 Macro VLU_SKIP_MASKED_EN defined: lanes with mask[i]=0 are not fetched; mask=0 goes from handshake directly to WB (vecwe at cycle 1, all waddr 0).
REQ-026 Macro VLU_SKIP_MASKED_EN undefined: all 4 lanes are always fetched; masked data is discarded per REQ-018.

Structure
REQ-027 A shared package vlu_pkg SHALL hold: the state enum, VLU_LANES=4, REG_AW=6, XLEN=32.
REQ-028 The block SHALL be a single module with no sub-modules; lane buffers are a 4-entry array indexed by the lane counter.

Verification
REQ-029 base=0x100, rd=1,2,33,34, mask=0xF, zero-wait memory returning addr^0xA5 -> addresses 0x100,0x104,0x108,0x10C in order; vecwe at cycle 9 with waddr 1,2,33,34 and wdata 0x1A5,0x1A1,0x1AD,0x1A9.
REQ-030 Same request with mask=0x5 -> waddr3=waddr5=0 and wdata3=wdata5=0; with VLU_SKIP_MASKED_EN, only 0x100 and 0x108 are requested and vecwe comes at cycle 5.
REQ-031 mem_req_ready held low 3 cycles on lane 2 -> mem_req_addr stays 0x108 and stable; vecwe is delayed by exactly 3 cycles.
REQ-032 rstn low during WAIT of lane 1, then response arrives -> no vecwe, busy=0, req_ready=1; a new request then completes normally.
REQ-033 base=0xFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4.
REQ-034 Spurious mem_resp_valid in IDLE, plus req_valid held high through WB -> no buffer corruption; second request accepted only the cycle after vecwe.
